kbd_fifo_port: RTL

- Port-mapped keyboard buffer for the kr580 system; replaces the single "last key + press counter" register pair at the board top level.
- Takes translated PS/2 bytes in the CPU clock domain and queues key events in a parametrised FIFO.
- Exposes data, status and control registers on the CPU port bus, with make/break and extended-prefix tracking.

---
 rtl/kbd_pkg.sv | 26 ++
 rtl/kbd_fifo.sv | 63 ++++++
 rtl/kbd_fifo_port.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared constants for the kr580 keyboard FIFO port: PS/2 prefixes,
// STATUS/CONTROL bit positions and the status count saturation helper.
package kbd_pkg;

  localparam logic [7:0] KBD_BREAK = 8'hF0;
  localparam logic [7:0] KBD_EXT   = 8'hE0;

  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_EXT      = 1;
  localparam int STAT_OVF      = 2;
  localparam int STAT_CNT_LSB  = 3;

  localparam int CTRL_FLUSH    = 0;
  localparam int CTRL_CLR_OVF  = 1;

  typedef enum logic [1:0] {
    SCAN_BREAK,
    SCAN_EXT,
    SCAN_ENTRY
  } scan_kind_e;

  function automatic logic [4:0] sat_count(input logic [8:0] c);
    return (c > 9'd31) ? 5'd31 : c[4:0];
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Generic synchronous DEPTH x 8 FIFO with push, pop, flush and occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module kbd_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot a same-cycle push needs, so full does not block it.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop  && !flush && !empty;

  // NOTE: every variable driven from always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kbd_fifo_port.sv
// Port-mapped keyboard buffer: PS/2 prefix tracking, event FIFO, DATA/STAT/CTRL ports.
// Optional autorepeat suppression is built when KBD_TYPEMATIC_FILTER_EN is defined.
module kbd_fifo_port
  import kbd_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] PORT_DATA = 8'hFE,
  parameter logic [7:0] PORT_STAT = 8'hFF,
  parameter logic [7:0] PORT_CTRL = 8'hFD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_raw,
  input  logic [7:0] scan_code,
  input  logic [7:0] port_addr,
  input  logic       port_wr,
  input  logic       port_rd,
  input  logic [7:0] port_wdata,
  output logic [7:0] port_rdata,
  output logic       irq
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          ovf_q, ovf_d;
  scan_kind_e    kind;
  logic [7:0]    entry;
  logic          is_entry, push_req;
  logic          ctrl_wr, flush, clr_ovf, pop;
  logic [7:0]    head;
  logic          full, empty;
  logic [PW-1:0] count;
  logic [7:0]    status;
  logic          unused_wdata;

  assign unused_wdata = ^port_wdata[7:2];

  assign ctrl_wr = port_wr && (port_addr == PORT_CTRL);
  assign flush   = ctrl_wr && port_wdata[CTRL_FLUSH];
  assign clr_ovf = ctrl_wr && port_wdata[CTRL_CLR_OVF];
  assign pop     = port_rd && (port_addr == PORT_DATA) && !empty;

  always_comb begin
    if (scan_raw == KBD_BREAK)    kind = SCAN_BREAK;
    else if (scan_raw == KBD_EXT) kind = SCAN_EXT;
    else                          kind = SCAN_ENTRY;
  end

  // Codes already in the Ex range carry their own meaning and bypass break tagging.
  assign entry    = (scan_code[7:4] == 4'hE) ? scan_code : {brk_q, scan_code[6:0]};
  assign is_entry = scan_valid && (kind == SCAN_ENTRY);

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic [7:0] last_make_q, last_make_d;
  logic       make_vld_q, make_vld_d;
  logic       repeat_drop;

  assign repeat_drop = make_vld_q && !brk_q && (entry == last_make_q);
  assign push_req    = is_entry && !flush && !repeat_drop;

  always_comb begin
    last_make_d = last_make_q;
    make_vld_d  = make_vld_q;
    if (flush) begin
      make_vld_d = 1'b0;
    end else if (is_entry) begin
      if (brk_q) begin
        if (entry[6:0] == last_make_q[6:0]) make_vld_d = 1'b0;
      end else begin
        last_make_d = entry;
        make_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_make_q <= 8'h00;
      make_vld_q  <= 1'b0;
    end else begin
      last_make_q <= last_make_d;
      make_vld_q  <= make_vld_d;
    end
  end
`else
  assign push_req = is_entry && !flush;
`endif

  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    ovf_d = ovf_q;
    if (flush) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (scan_valid) begin
      case (kind)
        SCAN_BREAK: brk_d = 1'b1;
        SCAN_EXT:   ext_d = 1'b1;
        default: begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      endcase
    end
    // A drop in the same cycle as a clear still leaves overflow set.
    if (clr_ovf) ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      ovf_q <= ovf_d;
    end
  end

  kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (entry),
    .pop   (pop),
    .flush (flush),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign status = {sat_count(9'(count)), ovf_q, ext_q, ~empty};

  always_comb begin
    if (port_addr == PORT_DATA)      port_rdata = empty ? 8'h00 : head;
    else if (port_addr == PORT_STAT) port_rdata = status;
    else                             port_rdata = 8'hFF;
  end

  assign irq = ~empty;

endmodule
